// File: rtl/led_mux_pwm.sv
// Multi-digit 7-segment scan driver with per-digit PWM brightness, enable and slot latching.
// Optional blink support is compiled in when LED_MUX_BLINK_EN is defined.
module led_mux_pwm #(
  parameter int NUM_DIGITS   = 8,
  parameter int SEG_W        = 8,
  parameter int PHASE_CYCLES = 781
`ifdef LED_MUX_BLINK_EN
  , parameter int BLINK_FRAMES = 256
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
  input  logic [NUM_DIGITS*4-1:0]     bright_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef LED_MUX_BLINK_EN
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       sel_out,
  output logic                        frame_start
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int DW = $clog2(NUM_DIGITS);

  logic [CW-1:0]    cyc_cnt;
  logic [3:0]       phase;
  logic [DW-1:0]    digit;
  logic [SEG_W-1:0] data_l;
  logic [3:0]       bright_l;
  logic             en_l;

  logic cyc_wrap, phase_wrap, slot_start, frame_first, lit;

  assign cyc_wrap    = (cyc_cnt == CW'(PHASE_CYCLES - 1));
  assign phase_wrap  = cyc_wrap && (phase == 4'd15);
  assign slot_start  = (cyc_cnt == '0) && (phase == 4'd0);
  assign frame_first = slot_start && (digit == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      phase   <= 4'd0;
      digit   <= '0;
    end else begin
      cyc_cnt <= cyc_wrap ? '0 : cyc_cnt + 1'b1;
      if (cyc_wrap)
        phase <= phase + 4'd1;
      // Explicit wrap so non-power-of-two digit counts never reach an unused index.
      if (phase_wrap)
        digit <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
    end
  end

  // Inputs for the current digit are sampled once, at the start of its slot, to avoid tearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_l   <= '1;
      bright_l <= 4'd0;
      en_l     <= 1'b0;
    end else if (slot_start) begin
      data_l   <= digits_in[int'(digit)*SEG_W +: SEG_W];
      bright_l <= bright_in[int'(digit)*4 +: 4];
      en_l     <= digit_en[digit];
    end
  end

`ifdef LED_MUX_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt;
  logic          blink_off;
  logic          mask_l;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
      mask_l    <= 1'b0;
    end else begin
      if (slot_start)
        mask_l <= blink_mask[digit];
      if (frame_first) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign lit = en_l && (phase != 4'd0) && (phase <= bright_l) && !(mask_l && blink_off);
`else
  // Phase 0 is always dark so the previous digit's anode can turn off before the next one drives.
  assign lit = en_l && (phase != 4'd0) && (phase <= bright_l);
`endif

  logic [NUM_DIGITS-1:0] sel_next;

  always_comb begin
    sel_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      sel_next[i] = !(lit && (digit == DW'(i)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out     <= '1;
      sel_out     <= '1;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= lit ? data_l : '1;
      sel_out     <= sel_next;
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_led_mux_pwm.sv
// Directed bench for led_mux_pwm: a 4-digit/2-cycle instance and a 5-digit/3-cycle instance.
module tb_led_mux_pwm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_DIGITS=4, PHASE_CYCLES=2 -> slot 32, frame 128 cycles
  logic [31:0] digits_in;
  logic [15:0] bright_in;
  logic [3:0]  digit_en;
  logic [7:0]  seg_out;
  logic [3:0]  sel_out;
  logic        frame_start;

  // Instance B: NUM_DIGITS=5, PHASE_CYCLES=3 -> slot 48, frame 240 cycles
  logic [39:0] b_digits;
  logic [19:0] b_bright;
  logic [4:0]  b_en;
  logic [7:0]  b_seg;
  logic [4:0]  b_sel;
  logic        b_fs;

  int tests_run    = 0;
  int tests_failed = 0;

  led_mux_pwm #(.NUM_DIGITS(4), .SEG_W(8), .PHASE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .digits_in(digits_in), .bright_in(bright_in),
    .digit_en(digit_en), .seg_out(seg_out), .sel_out(sel_out), .frame_start(frame_start)
  );

  led_mux_pwm #(.NUM_DIGITS(5), .SEG_W(8), .PHASE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .digits_in(b_digits), .bright_in(b_bright),
    .digit_en(b_en), .seg_out(b_seg), .sel_out(b_sel), .frame_start(b_fs)
  );

  // Expected anode pattern for instance A, f = cycles since reset release (counter-state time).
  function automatic logic [3:0] exp_sel4(int f, logic [15:0] br, logic [3:0] en);
    int fr = f % 128;
    int d  = fr / 32;
    int ph = (fr % 32) / 2;
    logic [3:0] s = 4'hF;
    if (en[d] && ph != 0 && ph <= int'(br[d*4 +: 4]))
      s[d] = 1'b0;
    return s;
  endfunction

  // Hold reset for two cycles, release on a falling edge.
  task automatic restart();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      digits_in = $urandom; bright_in = 16'($urandom); digit_en = 4'($urandom);
      b_digits = {8'($urandom), $urandom}; b_bright = 20'($urandom); b_en = 5'($urandom);
      @(negedge clk);
      tests_run++;
      if (sel_out !== 4'hF || seg_out !== 8'hFF || frame_start !== 1'b0 || b_sel !== 5'h1F) begin
        tests_failed++;
        $display("FAIL reset_hold sel=%b seg=%h fs=%b b_sel=%b required 1111 ff 0 11111",
                 sel_out, seg_out, frame_start, b_sel);
      end
    end
    digits_in = 32'h5566_7788; bright_in = 16'hFFFF; digit_en = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    // 40 cycles in: digit 1, phase 3 -> digit 1 lit
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (sel_out !== 4'hF || seg_out !== 8'hFF || frame_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async sel=%b seg=%h fs=%b required 1111 ff 0", sel_out, seg_out, frame_start);
    end
  endtask

  task automatic test_scan();
    int low[4] = '{0, 0, 0, 0};
    int fs_cnt = 0, fs_first = -1, fs_last = -1;
    logic [3:0] es; logic [7:0] eg; logic efs;
    digits_in = {8'hA3, 8'hB2, 8'hC1, 8'hD0}; bright_in = 16'hFFFF; digit_en = 4'hF;
    restart();
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      es  = exp_sel4(k - 1, bright_in, digit_en);
      eg  = (es == 4'hF) ? 8'hFF : digits_in[(((k - 1) % 128) / 32) * 8 +: 8];
      efs = (((k - 1) % 128) == 0);
      tests_run++;
      if (sel_out !== es || seg_out !== eg || frame_start !== efs) begin
        tests_failed++;
        $display("FAIL scan k=%0d sel=%b/%b seg=%h/%h fs=%b/%b (got/required)",
                 k, sel_out, es, seg_out, eg, frame_start, efs);
      end
      if (k <= 128)
        for (int d = 0; d < 4; d++) if (sel_out[d] === 1'b0) low[d]++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        fs_last = k;
      end
    end
    for (int d = 0; d < 4; d++) begin
      tests_run++;
      if (low[d] !== 30) begin
        tests_failed++;
        $display("FAIL scan_duty digit=%0d low=%0d required 30", d, low[d]);
      end
    end
    tests_run++;
    if (fs_cnt !== 2 || fs_last - fs_first !== 128) begin
      tests_failed++;
      $display("FAIL scan_frame_period pulses=%0d period=%0d required 2 128", fs_cnt, fs_last - fs_first);
    end
  endtask

  task automatic test_pwm();
    int on_cnt = 0, first_on = -1;
    logic [3:0] es;
    digits_in = 32'h1234_5678; bright_in = 16'h0040; digit_en = 4'hF;
    restart();
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      // Digit 1 slot starts at counter time 32; phases 1..4 cover counter times 34..41.
      es = (((k - 1) % 128) >= 34 && ((k - 1) % 128) <= 41) ? 4'b1101 : 4'hF;
      tests_run++;
      if (sel_out !== es || seg_out !== ((es == 4'hF) ? 8'hFF : 8'h56)) begin
        tests_failed++;
        $display("FAIL pwm k=%0d sel=%b required %b seg=%h", k, sel_out, es, seg_out);
      end
      if (k <= 128 && sel_out[1] === 1'b0) begin
        on_cnt++;
        if (first_on < 0) first_on = k;
      end
    end
    tests_run++;
    if (on_cnt !== 8 || first_on !== 35) begin
      tests_failed++;
      $display("FAIL pwm_window on=%0d first=%0d required 8 35", on_cnt, first_on);
    end
  endtask

  task automatic test_enable();
    int fs_cnt = 0, fs_first = -1, fs_last = -1, bad_low = 0;
    logic [3:0] es;
    digits_in = 32'hAABB_CCDD; bright_in = 16'h0FFF; digit_en = 4'b1011;
    restart();
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      es = exp_sel4(k - 1, bright_in, digit_en);
      tests_run++;
      if (sel_out !== es) begin
        tests_failed++;
        $display("FAIL enable k=%0d sel=%b required %b", k, sel_out, es);
      end
      if (sel_out[2] === 1'b0 || sel_out[3] === 1'b0) bad_low++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        fs_last = k;
      end
    end
    tests_run++;
    if (bad_low !== 0 || fs_cnt !== 2 || fs_last - fs_first !== 128) begin
      tests_failed++;
      $display("FAIL enable_dark lows=%0d pulses=%0d period=%0d required 0 2 128",
               bad_low, fs_cnt, fs_last - fs_first);
    end
  endtask

  task automatic test_tearing();
    logic [7:0] eg;
    int fr;
    digits_in = 32'h0000_0011; bright_in = 16'h000F; digit_en = 4'hF;
    restart();
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      fr = (k - 1) % 128;
      if (fr >= 2 && fr <= 31) eg = (k <= 128) ? 8'h11 : 8'h22;
      else eg = 8'hFF;
      tests_run++;
      if (seg_out !== eg) begin
        tests_failed++;
        $display("FAIL tearing k=%0d seg=%h required %h", k, seg_out, eg);
      end
      if (k == 10) digits_in[7:0] = 8'h22;
    end
  endtask

  task automatic test_wrap5();
    logic [4:0] es; logic [7:0] eg; logic efs;
    int fr, d, ph, fs_cnt = 0;
    b_digits = 40'h11_22_33_44_55; b_bright = 20'hFFFFF; b_en = 5'h1F;
    restart();
    for (int k = 1; k <= 480; k++) begin
      @(negedge clk);
      fr = (k - 1) % 240; d = fr / 48; ph = (fr % 48) / 3;
      es = 5'h1F;
      if (ph != 0) es[d] = 1'b0;
      eg  = (ph != 0) ? b_digits[d*8 +: 8] : 8'hFF;
      efs = (fr == 0);
      tests_run++;
      if (b_sel !== es || b_seg !== eg || b_fs !== efs) begin
        tests_failed++;
        $display("FAIL wrap5 k=%0d sel=%b/%b seg=%h/%h fs=%b/%b (got/required)",
                 k, b_sel, es, b_seg, eg, b_fs, efs);
      end
      if (b_fs === 1'b1) fs_cnt++;
    end
    tests_run++;
    if (fs_cnt !== 2) begin
      tests_failed++;
      $display("FAIL wrap5_frames pulses=%0d required 2", fs_cnt);
    end
  endtask

  initial begin
    digits_in = '1; bright_in = '0; digit_en = '0;
    b_digits = '1; b_bright = '0; b_en = '0;
    test_reset();
    test_scan();
    test_pwm();
    test_enable();
    test_tearing();
    test_wrap5();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
